// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store width
// codes, responder FSM states and byte-lane geometry.
package riscv_mem_pkg;

    // RV32I funct3 width/sign encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width of one byte lane within the 32-bit memory word
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the right-aligned pipeline data and the 32-bit
// memory word: store enables/replication and load extraction/extension.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_data,
    output logic        misalign,
    output logic        illegal,
    output logic [31:0] rdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rword[addr_lo*BYTE_W +: BYTE_W];
    assign half_v = addr_lo[1] ? rword[31:16] : rword[15:0];

    // Decode width into enables/lane data and extend the selected load field
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        byte_en   = 4'b0000;
        lane_data = 32'h0;
        misalign  = 1'b0;
        illegal   = 1'b0;
        rdata     = 32'h0;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en   = 4'b0001 << addr_lo;
                lane_data = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                byte_en   = 4'b0011 << addr_lo;
                lane_data = {2{wdata[15:0]}};
                misalign  = addr_lo[0];
            end
            F3_W: begin
                byte_en   = 4'b1111;
                lane_data = wdata;
                misalign  = (addr_lo != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
        case (funct3)
            F3_B:    rdata = {{24{byte_v[7]}}, byte_v};
            F3_BU:   rdata = {24'h0, byte_v};
            F3_H:    rdata = {{16{half_v[15]}}, half_v};
            F3_HU:   rdata = {16'h0, half_v};
            F3_W:    rdata = rword;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for the MEM stage: accepts one access,
// performs it LATENCY cycles later, returns a one-cycle response and stalls
// the pipeline while the access is outstanding.
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_stall
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [31:0] mem [DEPTH];

    // With LATENCY==1 the access happens on the accept edge, so it must use
    // the live request; otherwise it uses the captured copy.
    logic             sel_we;
    logic [2:0]       sel_f3;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rword;
    logic [3:0]       byte_en;
    logic [31:0]      lane_data;
    logic [31:0]      load_data;
    logic             misalign, illegal, out_of_range, acc_err;
    logic             do_access, mem_we;

    assign sel_we    = (state_q == IDLE) ? req_we     : we_q;
    assign sel_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
    assign sel_addr  = (state_q == IDLE) ? req_addr   : addr_q;
    assign sel_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;

    assign word_idx     = sel_addr[IDX_W+1:2];
    assign rword        = mem[word_idx];
    assign out_of_range = (sel_addr[31:2] >= 30'(DEPTH));
    assign acc_err      = illegal || misalign || out_of_range;

    mem_lane_align u_align (
        .funct3    (sel_f3),
        .addr_lo   (sel_addr[1:0]),
        .wdata     (sel_wdata),
        .rword     (rword),
        .byte_en   (byte_en),
        .lane_data (lane_data),
        .misalign  (misalign),
        .illegal   (illegal),
        .rdata     (load_data)
    );

    // Next-state, latency counter, request capture and response computation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 1) begin
                        do_access = 1'b1;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (do_access) begin
            err_d   = acc_err;
            rdata_d = (acc_err || sel_we) ? 32'h0 : load_data;
        end
    end

    // Reset wins over an access on the same edge, so a pending store is dropped
    assign mem_we = do_access && sel_we && !acc_err && !reset;

    // Control and capture registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte-enabled write into the storage array
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; contents survive reset and clearing
        // it would prevent mapping onto RAM macros.
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][i*BYTE_W +: BYTE_W] <= lane_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_stall = ((state_q == IDLE) && req_valid) || (state_q == WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a LATENCY=2 and a LATENCY=1
// instance share the request bus; responses are checked by a scoreboard.
module tb_data_mem_responder;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        sel;          // 0 = LATENCY 2 instance, 1 = LATENCY 1 instance
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        rv2, ready2, rsp_valid2, err2, stall2;
    logic        rv1, ready1, rsp_valid1, err1, stall1;
    logic [31:0] rdata2, rdata1;

    logic        cur_ready, cur_valid, cur_err, cur_stall;
    logic [31:0] cur_rdata;

    assign rv2 = req_valid && !sel;
    assign rv1 = req_valid && sel;

    assign cur_ready = sel ? ready1     : ready2;
    assign cur_valid = sel ? rsp_valid1 : rsp_valid2;
    assign cur_err   = sel ? err1       : err2;
    assign cur_stall = sel ? stall1     : stall2;
    assign cur_rdata = sel ? rdata1     : rdata2;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset), .req_valid(rv2), .req_ready(ready2),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid2), .rsp_rdata(rdata2),
        .rsp_err(err2), .mem_stall(stall2)
    );

    data_mem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(ready1),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid1), .rsp_rdata(rdata1),
        .rsp_err(err1), .mem_stall(stall1)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic err);
        vec_t v;
        v.name = name; v.we = we; v.f3 = f3; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.err = err;
        vecs.push_back(v);
    endtask

    // Scoreboard: every response of the selected instance must match the oldest expectation
    always @(negedge clk) begin
        if (cur_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_rsp", 32'(cur_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_rdata"}, cur_rdata, mon_e.rdata);
                check({mon_e.name, "_err"}, 32'(cur_err), 32'(mon_e.err));
            end
        end
    end

    // The instance not under test must stay silent
    always @(negedge clk) begin
        if ((sel ? rsp_valid2 : rsp_valid1) === 1'b1)
            check("idle_dut_rsp", 32'd1, 32'd0);
    end

    // Drive one access (called just after a negedge) and check handshake timing;
    // returns at the negedge inside the RESP cycle. hold keeps req_valid high.
    task automatic xact(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic err, input logic hold);
        int   lat;
        int   tries;
        exp_t e;
        lat        = sel ? 1 : 2;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        tries      = 0;
        #1;
        while (cur_ready !== 1'b1 && tries < 10) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (cur_ready !== 1'b1) begin
            check({name, "_ready_timeout"}, 32'(cur_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        check({name, "_stall_accept"}, 32'(cur_stall), 32'd1);
        e.name = name; e.rdata = rdata; e.err = err;
        sb.push_back(e);
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check({name, "_rsp_valid_timing"}, 32'(cur_valid), 32'(k == lat));
            check({name, "_stall_timing"}, 32'(cur_stall), 32'(k != lat));
            if (k == lat) check({name, "_ready_in_resp"}, 32'(cur_ready), 32'd0);
            if (!hold) req_valid = 1'b0;
            if (k < lat) @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; sel = 1'b0;
        req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h0; req_wdata = 32'h0;

        // Reset state of both instances
        repeat (2) @(negedge clk);
        check("rst_ready2", 32'(ready2), 32'd1);
        check("rst_valid2", 32'(rsp_valid2), 32'd0);
        check("rst_rdata2", rdata2, 32'h0);
        check("rst_err2", 32'(err2), 32'd0);
        check("rst_stall2", 32'(stall2), 32'd0);
        check("rst_ready1", 32'(ready1), 32'd1);
        check("rst_valid1", 32'(rsp_valid1), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table of independent accesses on the LATENCY=2 instance
        add("sw_10",   1'b1, F3_W,   32'h10,   32'hDEADBEEF, 32'h0,        1'b0);
        add("lw_10",   1'b0, F3_W,   32'h10,   32'h0,        32'hDEADBEEF, 1'b0);
        add("sb_13",   1'b1, F3_B,   32'h13,   32'h000000AA, 32'h0,        1'b0);
        add("lw_10b",  1'b0, F3_W,   32'h10,   32'h0,        32'hAAADBEEF, 1'b0);
        add("lb_13",   1'b0, F3_B,   32'h13,   32'h0,        32'hFFFFFFAA, 1'b0);
        add("lbu_13",  1'b0, F3_BU,  32'h13,   32'h0,        32'h000000AA, 1'b0);
        add("lh_12",   1'b0, F3_H,   32'h12,   32'h0,        32'hFFFFAAAD, 1'b0);
        add("lhu_10",  1'b0, F3_HU,  32'h10,   32'h0,        32'h0000BEEF, 1'b0);
        add("lb_10",   1'b0, F3_B,   32'h10,   32'h0,        32'hFFFFFFEF, 1'b0);
        add("lh_11",   1'b0, F3_H,   32'h11,   32'h0,        32'h0,        1'b1);
        add("sw_12",   1'b1, F3_W,   32'h12,   32'h11111111, 32'h0,        1'b1);
        add("lw_10c",  1'b0, F3_W,   32'h10,   32'h0,        32'hAAADBEEF, 1'b0);
        add("f3_011",  1'b0, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1);
        add("sh_12",   1'b1, F3_H,   32'h12,   32'h00001234, 32'h0,        1'b0);
        add("lw_10d",  1'b0, F3_W,   32'h10,   32'h0,        32'h1234BEEF, 1'b0);
        add("lhu_12",  1'b0, F3_HU,  32'h12,   32'h0,        32'h00001234, 1'b0);
        add("sw_0",    1'b1, F3_W,   32'h0,    32'h55AA55AA, 32'h0,        1'b0);
        add("sw_ffc",  1'b1, F3_W,   32'hFFC,  32'h0BADCAFE, 32'h0,        1'b0);
        add("lw_ffc",  1'b0, F3_W,   32'hFFC,  32'h0,        32'h0BADCAFE, 1'b0);
        add("lw_1000", 1'b0, F3_W,   32'h1000, 32'h0,        32'h0,        1'b1);
        add("sw_1000", 1'b1, F3_W,   32'h1000, 32'hFFFFFFFF, 32'h0,        1'b1);
        add("lw_0",    1'b0, F3_W,   32'h0,    32'h0,        32'h55AA55AA, 1'b0);
        add("st_110",  1'b1, 3'b110, 32'h0,    32'h0,        32'h0,        1'b1);
        add("lw_0b",   1'b0, F3_W,   32'h0,    32'h0,        32'h55AA55AA, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            xact(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                 vecs[i].rdata, vecs[i].err, 1'b0);
            @(negedge clk);
        end

        // req_valid held through RESP: no re-accept, next accept one cycle later
        xact("hold_a", 1'b1, F3_W, 32'h30, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        check("hold_idle_ready", 32'(cur_ready), 32'd1);
        check("hold_idle_stall", 32'(cur_stall), 32'd1);
        xact("hold_b", 1'b0, F3_W, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1);
        xact("hold_c", 1'b0, F3_HU, 32'h32, 32'h0, 32'h0000A5A5, 1'b0, 1'b0);
        @(negedge clk);

        // Same handshake on the LATENCY=1 instance: one stall cycle per access
        sel = 1'b1;
        @(negedge clk);
        xact("l1_sw_40", 1'b1, F3_W, 32'h40, 32'h01020304, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        check("l1_hold_ready", 32'(cur_ready), 32'd1);
        check("l1_hold_stall", 32'(cur_stall), 32'd1);
        xact("l1_lw_40", 1'b0, F3_W, 32'h40, 32'h0, 32'h01020304, 1'b0, 1'b1);
        xact("l1_lb_41", 1'b0, F3_B, 32'h41, 32'h0, 32'h00000003, 1'b0, 1'b0);
        @(negedge clk);
        sel = 1'b0;
        @(negedge clk);

        // Reset during WAIT abandons a store; reset with a new request accepts nothing
        xact("sw_20", 1'b1, F3_W, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_wait", 32'(ready2), 32'd0);
        reset = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_ready_in_reset", 32'(ready2), 32'd1);
        check("abort_no_rsp", 32'(rsp_valid2), 32'd0);
        req_addr = 32'h24; req_wdata = 32'h77777777; req_valid = 1'b1;
        @(negedge clk);
        check("rst_vs_accept_ready", 32'(ready2), 32'd1);
        req_valid = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_no_rsp", 32'(rsp_valid2), 32'd0);
        end
        xact("lw_20", 1'b0, F3_W, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
